seq_mag_comparator: RTL and testbench



---
 rtl/seq_mag_comparator.sv | 149 ++++++++++++++
 tb/tb_seq_mag_comparator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator
//
// Multi-cycle magnitude comparator. The operands are captured on an accepted
// start, then compared one DIGIT-bit slice per cycle, most significant slice
// first. The comparison stops at the first slice that differs. If every slice
// is equal, the result is eq after N = WIDTH/DIGIT cycles.
//
// Optional feature (macro CMP_SIGNED_EN):
//   When defined, this adds input i_signed_mode. It is sampled with start.
//   When it is 1, the operands are treated as two's complement numbers.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   i_signed_mode  (CMP_SIGNED_EN only) 1 = signed comparison
//   i_start        requests a comparison; accepted in IDLE or DONE only
//   i_a, i_b       operands; captured on the accepted start edge
//   o_busy         high while the comparison is running
//   o_done         one-cycle pulse; the result flags are valid
//   o_gt/o_eq/o_lt result flags, held until the next accepted start
`timescale 1ns/1ps
module seq_mag_comparator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CMP_SIGNED_EN
  input  logic             i_signed_mode,
`endif
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_gt,
  output logic             o_eq,
  output logic             o_lt
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  if ((WIDTH % DIGIT) != 0 || WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH) begin : g_param_check
    $error("seq_mag_comparator: WIDTH must be a multiple of DIGIT, WIDTH >= 2");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_a, r_b;
  logic [CntW-1:0]   r_cnt;
  logic              r_gt, r_eq, r_lt;
  logic              w_accept;
  logic              w_msb_flip;
  logic [WIDTH-1:0]  w_a_eff, w_b_eff;
  logic [DIGIT-1:0]  w_sa, w_sb;
  logic              w_last;
  int unsigned       w_msb_idx;

`ifdef CMP_SIGNED_EN
  logic r_signed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_signed <= 1'b0;
    end else if (w_accept) begin
      r_signed <= i_signed_mode;
    end
  end

  assign w_msb_flip = r_signed;
`else
  assign w_msb_flip = 1'b0;
`endif

  // Inverting the sign bit of both operands turns the two's complement order
  // into the unsigned order. The rest of the datapath then stays unsigned.
  assign w_a_eff = r_a ^ {w_msb_flip, {(WIDTH-1){1'b0}}};
  assign w_b_eff = r_b ^ {w_msb_flip, {(WIDTH-1){1'b0}}};

  // The counter never exceeds N-1, so this index always stays in range.
  assign w_msb_idx = WIDTH - 1 - (32'(r_cnt) * DIGIT);
  assign w_sa      = w_a_eff[w_msb_idx -: DIGIT];
  assign w_sb      = w_b_eff[w_msb_idx -: DIGIT];
  assign w_last    = (r_cnt == LastCnt);

  assign w_accept  = i_start && (r_state == StIdle || r_state == StDone);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_nxt = StRun;
      StRun:   if ((w_sa != w_sb) || w_last) w_state_nxt = StDone;
      StDone:  w_state_nxt = i_start ? StRun : StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Operand capture, slice counter and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_cnt <= '0;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else if (r_state == StRun) begin
      if (w_sa > w_sb) begin
        r_gt <= 1'b1;
      end else if (w_sa < w_sb) begin
        r_lt <= 1'b1;
      end else if (w_last) begin
        r_eq <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Output logic
  always_comb begin
    o_busy = (r_state == StRun);
    o_done = (r_state == StDone);
    o_gt   = r_gt;
    o_eq   = r_eq;
    o_lt   = r_lt;
  end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed self-checking bench for seq_mag_comparator (WIDTH=16, DIGIT=4).
`timescale 1ns/1ps
module tb_seq_mag_comparator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [15:0] i_a = '0;
  logic [15:0] i_b = '0;
`ifdef CMP_SIGNED_EN
  logic        i_signed_mode = 1'b0;
`endif
  logic        o_busy, o_done, o_gt, o_eq, o_lt;

  int n_vec = 0;
  int n_err = 0;

  seq_mag_comparator #(.WIDTH(16), .DIGIT(4)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef CMP_SIGNED_EN
    .i_signed_mode(i_signed_mode),
`endif
    .i_start      (i_start),
    .i_a          (i_a),
    .i_b          (i_b),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_gt         (o_gt),
    .o_eq         (o_eq),
    .o_lt         (o_lt)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {o_busy, o_done, o_gt, o_eq, o_lt};
  endfunction

  // Issue one start and count the edges until done (bounded to 20 cycles).
  task automatic run_cmp(input logic [15:0] a, input logic [15:0] b,
                         output int lat, output int busy_cycles);
    @(negedge clk);
    i_a = a; i_b = b; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    lat = 0;
    busy_cycles = o_busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (o_done) break;
      if (o_busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (outs() !== 5'b00000) begin
      n_err++; $display("FAIL reset_outs: got %b expected %b", outs(), 5'b00000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (outs() !== 5'b00000) begin
      n_err++; $display("FAIL idle_outs: got %b expected %b", outs(), 5'b00000);
    end
  endtask

  task automatic test_gt();
    int lat, bc;
    run_cmp(16'h8000, 16'h7FFF, lat, bc);
    n_vec++;
    if (lat !== 1) begin n_err++; $display("FAIL gt_latency: got %0d expected 1", lat); end
    n_vec++;
    if (bc !== 1) begin n_err++; $display("FAIL gt_busy_cycles: got %0d expected 1", bc); end
    n_vec++;
    if (outs() !== 5'b01100) begin
      n_err++; $display("FAIL gt_flags: got %b expected %b", outs(), 5'b01100);
    end
    @(posedge clk); #1;
    n_vec++;
    if (outs() !== 5'b00100) begin
      n_err++; $display("FAIL gt_hold_after_done: got %b expected %b", outs(), 5'b00100);
    end
  endtask

  task automatic test_eq();
    int lat, bc;
    run_cmp(16'h1234, 16'h1234, lat, bc);
    n_vec++;
    if (lat !== 4) begin n_err++; $display("FAIL eq_latency: got %0d expected 4", lat); end
    n_vec++;
    if (bc !== 4) begin n_err++; $display("FAIL eq_busy_cycles: got %0d expected 4", bc); end
    n_vec++;
    if (outs() !== 5'b01010) begin
      n_err++; $display("FAIL eq_flags: got %b expected %b", outs(), 5'b01010);
    end
  endtask

  // Pulses start during RUN and changes the operands after capture.
  // Neither of these may affect the result.
  task automatic test_lt_ignore_start();
    int lat;
    @(negedge clk);
    i_a = 16'h12A4; i_b = 16'h12B4; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_a = 16'hFFFF; i_b = 16'h0000;
    n_vec++;
    if (outs() !== 5'b10000) begin
      n_err++; $display("FAIL lt_running: got %b expected %b", outs(), 5'b10000);
    end
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      i_start = (i < 2) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      lat++;
      if (o_done) break;
    end
    i_start = 1'b0;
    n_vec++;
    if (lat !== 3) begin n_err++; $display("FAIL lt_latency: got %0d expected 3", lat); end
    n_vec++;
    if (outs() !== 5'b01001) begin
      n_err++; $display("FAIL lt_flags: got %b expected %b", outs(), 5'b01001);
    end
    @(posedge clk); #1;
    n_vec++;
    if (outs() !== 5'b00001) begin
      n_err++; $display("FAIL lt_back_to_idle: got %b expected %b", outs(), 5'b00001);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    i_a = 16'd5; i_b = 16'd3; i_start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (o_done) break;
    end
    n_vec++;
    if (lat !== 4) begin n_err++; $display("FAIL b2b_first_latency: got %0d expected 4", lat); end
    n_vec++;
    if (outs() !== 5'b01100) begin
      n_err++; $display("FAIL b2b_first_flags: got %b expected %b", outs(), 5'b01100);
    end
    i_a = 16'd3; i_b = 16'd5;
    @(posedge clk); #1;
    i_start = 1'b0;
    n_vec++;
    if (outs() !== 5'b10000) begin
      n_err++; $display("FAIL b2b_no_idle: got %b expected %b", outs(), 5'b10000);
    end
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (o_done) break;
    end
    n_vec++;
    if (lat !== 4) begin n_err++; $display("FAIL b2b_second_latency: got %0d expected 4", lat); end
    n_vec++;
    if (outs() !== 5'b01001) begin
      n_err++; $display("FAIL b2b_second_flags: got %b expected %b", outs(), 5'b01001);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, done_seen;
    @(negedge clk);
    i_a = 16'h1234; i_b = 16'h1234; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (outs() !== 5'b00000) begin
      n_err++; $display("FAIL midrun_reset_outs: got %b expected %b", outs(), 5'b00000);
    end
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (o_done) done_seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (o_done) done_seen++;
    end
    n_vec++;
    if (done_seen !== 0) begin
      n_err++; $display("FAIL midrun_no_done: got %0d done cycles expected 0", done_seen);
    end
    run_cmp(16'h8000, 16'h7FFF, lat, bc);
    n_vec++;
    if (lat !== 1) begin n_err++; $display("FAIL post_reset_latency: got %0d expected 1", lat); end
    n_vec++;
    if (outs() !== 5'b01100) begin
      n_err++; $display("FAIL post_reset_flags: got %b expected %b", outs(), 5'b01100);
    end
  endtask

`ifdef CMP_SIGNED_EN
  task automatic test_signed();
    int lat, bc;
    i_signed_mode = 1'b1;
    run_cmp(16'hFFFF, 16'h0001, lat, bc);
    n_vec++;
    if (outs() !== 5'b01001) begin
      n_err++; $display("FAIL signed_lt: got %b expected %b", outs(), 5'b01001);
    end
    i_signed_mode = 1'b0;
    run_cmp(16'hFFFF, 16'h0001, lat, bc);
    n_vec++;
    if (outs() !== 5'b01100) begin
      n_err++; $display("FAIL unsigned_gt: got %b expected %b", outs(), 5'b01100);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_gt();
    test_eq();
    test_lt_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
`ifdef CMP_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
